// File: rtl/pipe_fixed_to_float32.sv
// pipe_fixed_to_float32: 3-stage signed Q(WII.WIF) to float32 converter.
// Define FXP2F_ROUND_EN for round-to-nearest-even; default truncates.
module pipe_fixed_to_float32 #(
  parameter int WII = 8,
  parameter int WIF = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [WII+WIF-1:0] i_data,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [31:0]        o_data,
  output logic               o_sat,
  output logic               o_uflow
);

  localparam int N  = WII + WIF;
  localparam int PW = $clog2(N);
  localparam int EW = $clog2(N) + 10;

  localparam logic signed [EW-1:0] EXP_MAX = EW'(255);
  localparam logic signed [EW-1:0] EXP_MIN = '0;

  logic rdy1, rdy2, rdy3;

  logic         v1_q;
  logic         s1_sign_q, s1_sign_d;
  logic         s1_zero_q, s1_zero_d;
  logic [N-1:0] s1_mag_q, s1_mag_d;

  logic                 v2_q;
  logic                 s2_sign_q;
  logic                 s2_zero_q;
  logic [N-1:0]         s2_norm_q, s2_norm_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [PW-1:0]        lz_p;

  logic                 v3_q;
  logic [31:0]          s3_data_q, s3_data_d;
  logic                 s3_sat_q, s3_sat_d;
  logic                 s3_uf_q, s3_uf_d;
  logic [N+22:0]        s3_ext;
  logic [22:0]          s3_mant;
  logic signed [EW-1:0] s3_exp;
  logic                 unused_bits;

  // Backpressure ripples combinationally from o_ready to i_ready.
  assign rdy3    = ~v3_q | o_ready;
  assign rdy2    = ~v2_q | rdy3;
  assign rdy1    = ~v1_q | rdy2;
  assign i_ready = rdy1;

  always_comb begin
    s1_sign_d = i_data[N-1];
    s1_mag_d  = s1_sign_d ? (~i_data + N'(1)) : i_data;
    s1_zero_d = ~|s1_mag_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_mag_q  <= '0;
    end else if (rdy1) begin
      v1_q <= i_valid;
      if (i_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_zero_q <= s1_zero_d;
        s1_mag_q  <= s1_mag_d;
      end
    end
  end

  always_comb begin
    lz_p = '0;
    for (int i = 0; i < N; i++) begin
      if (s1_mag_q[i]) lz_p = PW'(i);
    end
    s2_norm_d = s1_mag_q << (PW'(N - 1) - lz_p);
    s2_exp_d  = EW'(lz_p) - EW'(WIF) + EW'(127);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q      <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_norm_q <= '0;
      s2_exp_q  <= '0;
    end else if (rdy2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_norm_q <= s2_norm_d;
        s2_exp_q  <= s2_exp_d;
      end
    end
  end

`ifdef FXP2F_ROUND_EN
  logic s3_guard, s3_sticky, s3_inc, s3_carry;
  logic [22:0] s3_mant_t;

  always_comb begin
    s3_ext    = {s2_norm_q[N-2:0], 24'd0};
    s3_mant_t = s3_ext[N+22 -: 23];
    s3_guard  = s3_ext[N-1];
    s3_sticky = |s3_ext[N-2:0];
    s3_inc    = s3_guard & (s3_sticky | s3_mant_t[0]);
    // A carry only occurs from all-ones, so the wrapped mantissa is zero.
    {s3_carry, s3_mant} = {1'b0, s3_mant_t} + {23'd0, s3_inc};
    s3_exp = s2_exp_q + EW'(s3_carry);
  end

  assign unused_bits = s2_norm_q[N-1];
`else
  always_comb begin
    s3_ext  = {s2_norm_q[N-2:0], 24'd0};
    s3_mant = s3_ext[N+22 -: 23];
    s3_exp  = s2_exp_q;
  end

  assign unused_bits = ^{s2_norm_q[N-1], s3_ext[N-1:0]};
`endif

  always_comb begin
    s3_sat_d = 1'b0;
    s3_uf_d  = 1'b0;
    if (s2_zero_q) begin
      s3_data_d = '0;
    end else if (s3_exp >= EXP_MAX) begin
      s3_data_d = {s2_sign_q, 8'hFE, 23'h7FFFFF};
      s3_sat_d  = 1'b1;
    end else if (s3_exp <= EXP_MIN) begin
      s3_data_d = {s2_sign_q, 31'd0};
      s3_uf_d   = 1'b1;
    end else begin
      s3_data_d = {s2_sign_q, s3_exp[7:0], s3_mant};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3_q      <= 1'b0;
      s3_data_q <= '0;
      s3_sat_q  <= 1'b0;
      s3_uf_q   <= 1'b0;
    end else if (rdy3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        s3_data_q <= s3_data_d;
        s3_sat_q  <= s3_sat_d;
        s3_uf_q   <= s3_uf_d;
      end
    end
  end

  assign o_valid = v3_q;
  assign o_data  = s3_data_q;
  assign o_sat   = s3_sat_q;
  assign o_uflow = s3_uf_q;

endmodule

// File: tb/tb_pipe_fixed_to_float32.sv
// tb_pipe_fixed_to_float32: scoreboard bench over four parameter sets.
// Expected {sat, uflow, data} words are queued at send and popped at output.
module tb_pipe_fixed_to_float32;

  logic clk = 1'b0;
  logic rstn;

  logic [3:0]   iv, ir, ov, orr, os, ou;
  logic [31:0]  od [4];
  logic [15:0]  d0;
  logic [31:0]  d1;
  logic [130:0] d2;
  logic [147:0] d3;

  int checks = 0;
  int errors = 0;

  logic [33:0] q [4][$];
  logic [33:0] held [4];
  logic [3:0]  hv = '0;
  int          npop [4] = '{default: 0};

  logic [15:0] bp [10] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h1234,
                           16'hABCD, 16'h0100, 16'hFF00, 16'h00FF,
                           16'h8001, 16'h4000};

  always #5 clk = ~clk;

  pipe_fixed_to_float32 #(.WII(8), .WIF(8)) u0 (
    .clk(clk), .rstn(rstn), .i_valid(iv[0]), .i_ready(ir[0]),
    .i_data(d0), .o_valid(ov[0]), .o_ready(orr[0]), .o_data(od[0]),
    .o_sat(os[0]), .o_uflow(ou[0]));

  pipe_fixed_to_float32 #(.WII(32), .WIF(0)) u1 (
    .clk(clk), .rstn(rstn), .i_valid(iv[1]), .i_ready(ir[1]),
    .i_data(d1), .o_valid(ov[1]), .o_ready(orr[1]), .o_data(od[1]),
    .o_sat(os[1]), .o_uflow(ou[1]));

  pipe_fixed_to_float32 #(.WII(131), .WIF(0)) u2 (
    .clk(clk), .rstn(rstn), .i_valid(iv[2]), .i_ready(ir[2]),
    .i_data(d2), .o_valid(ov[2]), .o_ready(orr[2]), .o_data(od[2]),
    .o_sat(os[2]), .o_uflow(ou[2]));

  pipe_fixed_to_float32 #(.WII(8), .WIF(140)) u3 (
    .clk(clk), .rstn(rstn), .i_valid(iv[3]), .i_ready(ir[3]),
    .i_data(d3), .o_valid(ov[3]), .o_ready(orr[3]), .o_data(od[3]),
    .o_sat(os[3]), .o_uflow(ou[3]));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference for Q8.8: value fits 16 bits, so the float is always exact.
  function automatic logic [33:0] ref16(input logic [15:0] x);
    int m, p;
    logic [31:0] f;
    if (x == 16'd0) return 34'd0;
    m = x[15] ? 65536 - int'(x) : int'(x);
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    f = {x[15], 8'(p + 119), 23'((m << (23 - p)) & 32'h7FFFFF)};
    return {2'b00, f};
  endfunction

  task automatic send(input int k, input logic [255:0] d,
                      input logic [33:0] e);
    int n = 0;
    logic acc = 1'b0;
    case (k)
      0: d0 = d[15:0];
      1: d1 = d[31:0];
      2: d2 = d[130:0];
      default: d3 = d[147:0];
    endcase
    iv[k] = 1'b1;
    q[k].push_back(e);
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ir[k];
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("accept%0d", k), 64'(acc), 64'd1);
    iv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (q[k].size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("drain%0d", k), 64'(q[k].size()), 64'd0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ov[k] && orr[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("unexpected_out%0d", k), 64'(ov[k]), 64'd0);
        end else begin
          chk($sformatf("out%0d", k), 64'({os[k], ou[k], od[k]}),
              64'(q[k].pop_front()));
          npop[k] <= npop[k] + 1;
        end
        hv[k] <= 1'b0;
      end else if (ov[k]) begin
        if (hv[k])
          chk($sformatf("hold_stable%0d", k),
              64'({os[k], ou[k], od[k]}), 64'(held[k]));
        held[k] <= {os[k], ou[k], od[k]};
        hv[k]   <= 1'b1;
      end else begin
        hv[k] <= 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [130:0] neg131;
    rstn = 1'b0;
    iv   = '0;
    orr  = '1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_ov%0d", k), 64'(ov[k]), 64'd0);
      chk($sformatf("rst_ir%0d", k), 64'(ir[k]), 64'd1);
    end
    chk("rst_out0", 64'({os[0], ou[0], od[0]}), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ir", 64'(ir[0]), 64'd1);

    send(0, 256'h0180, {2'b00, 32'h3FC00000});
    chk("lat_t", 64'(ov[0]), 64'd0);
    send(0, 256'hFF80, {2'b00, 32'hBF000000});
    chk("lat_t1", 64'(ov[0]), 64'd0);
    send(0, 256'h0000, 34'd0);
    chk("lat_t2_v", 64'(ov[0]), 64'd1);
    chk("lat_t2_d", 64'(od[0]), 64'h3FC00000);
    send(0, 256'h8000, {2'b00, 32'hC3000000});
    chk("tput_d", 64'(od[0]), 64'hBF000000);
    drain(0);

    p0 = npop[0];
    send(0, 256'(bp[0]), ref16(bp[0]));
    send(0, 256'(bp[1]), ref16(bp[1]));
    orr[0] = 1'b0;
    send(0, 256'(bp[2]), ref16(bp[2]));
    chk("full_irdy", 64'(ir[0]), 64'd0);
    iv[0] = 1'b1;
    d0    = bp[3];
    q[0].push_back(ref16(bp[3]));
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("bp_irdy", 64'(ir[0]), 64'd0);
      chk("bp_ov", 64'(ov[0]), 64'd1);
    end
    orr[0] = 1'b1;
    #1;
    chk("simul_irdy", 64'(ir[0]), 64'd1);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    for (int i = 4; i < 10; i++) send(0, 256'(bp[i]), ref16(bp[i]));
    drain(0);
    chk("bp_count", 64'(npop[0] - p0), 64'd10);

    orr[0] = 1'b0;
    send(0, 256'h0300, ref16(16'h0300));
    send(0, 256'hFD00, ref16(16'hFD00));
    @(posedge clk);
    #1;
    chk("pre_rst_ov", 64'(ov[0]), 64'd1);
    rstn = 1'b0;
    #1;
    chk("async_rst_ov", 64'(ov[0]), 64'd0);
    chk("async_rst_ir", 64'(ir[0]), 64'd1);
    q[0].delete();
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    orr[0] = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("no_stale", 64'(ov[0]), 64'd0);
    end

`ifdef FXP2F_ROUND_EN
    send(1, 256'h01000001, {2'b00, 32'h4B800000});
    send(1, 256'h01000003, {2'b00, 32'h4B800002});
`else
    send(1, 256'h01000001, {2'b00, 32'h4B800000});
    send(1, 256'h01000003, {2'b00, 32'h4B800001});
`endif
    send(1, 256'h00FFFFFF, {2'b00, 32'h4B7FFFFF});
    drain(1);

    neg131 = 131'd0 - (131'd1 << 129);
    send(2, 256'd1 << 129, {2'b10, 32'h7F7FFFFF});
    send(2, 256'(neg131), {2'b10, 32'hFF7FFFFF});
    drain(2);

    send(3, 256'd1, {2'b01, 32'h00000000});
    send(3, 256'({148{1'b1}}), {2'b01, 32'h80000000});
    send(3, 256'd0, 34'd0);
    send(3, 256'd1 << 140, {2'b00, 32'h3F800000});
    send(3, 256'd1 << 14, {2'b00, 32'h00800000});
    send(3, 256'd1 << 13, {2'b01, 32'h00000000});
    drain(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_fixed_to_float32.md
# pipe_fixed_to_float32

Pipelined, parametrised fixed-point to IEEE-754 single-precision converter with valid/ready flow control. It accepts one signed two's-complement Q(WII.WIF) sample per cycle and produces a float32 after three register stages. Optional round-to-nearest-even is available, along with saturation and flush-to-zero status. It sits between fixed-point datapaths and float consumers that can apply backpressure.

## Interface
- WII, default 8: integer bits including sign; 1..256.
- WIF, default 8: fraction bits; 0..255; N = WII+WIF must be 2..256.
- clk  input  1: clock; all state changes on the rising edge.
- rstn  input  1: asynchronous, active-low reset.
- i_valid  input  1: input sample valid.
- i_ready  output  1: block can accept; i_valid & i_ready on an edge transfers one sample.
- i_data  input  N: signed fixed-point value = i_data / 2^WIF.
- o_valid  output  1: output result valid.
- o_ready  input  1: consumer accepts; o_valid & o_ready on an edge transfers one result.
- o_data  output  32: float32 {sign, exp[7:0], mant[22:0]}.
- o_sat  output  1: result was saturated to ±max finite (sideband of o_data).
- o_uflow  output  1: nonzero input was flushed to zero (sideband of o_data).

## Operation
- Three register stages (S1, S2, S3), each holding a valid bit. S3 drives o_valid, o_data, o_sat and o_uflow.
- Stage handshake: rdy3 = ~v3 | o_ready, rdy2 = ~v2 | rdy3, rdy1 = ~v1 | rdy2, i_ready = rdy1. This gives a combinational path from o_ready to i_ready.
- Each stage loads when its rdy is 1. It captures the upstream valid and data, or clears its valid when upstream is empty. A stage whose rdy is 0 holds its contents.
- S1 computes:
  - sign = i_data[N-1].
  - mag = sign ? -i_data : i_data as an N-bit unsigned value. The most negative input gives mag = 2^(N-1), which is correct unsigned.
  - zero = (mag == 0).
- S2 computes:
  - p = index of the leading one of mag.
  - norm = mag << (N-1-p), so the leading one sits at the MSB.
  - e = p - WIF + 127, as a signed value at least clog2(N)+10 bits wide.
- S3 computes:
  - mant = the 23 bits below the MSB of norm, zero-padded when N < 24.
  - Rounding per the Configuration section. A mantissa carry-out sets mant = 0 and e = e+1.
  - zero input: o_data = 0x00000000, o_sat = 0, o_uflow = 0.
  - e >= 255 (including after round carry): o_data = {sign, 8'hFE, 23'h7FFFFF}, o_sat = 1.
  - e <= 0: o_data = {sign, 31'h0}, o_uflow = 1. No denormals are produced.
  - Otherwise: o_data = {sign, e[7:0], mant}.
- Reset value of every output:
  - o_valid = 0, o_data = 0, o_sat = 0, o_uflow = 0.
  - All stage valids = 0, so i_ready = 1 immediately after reset.
- Reset asserted mid-operation discards all in-flight samples. No partial result is emitted.

## Timing
- Latency: a sample accepted on edge t is presented on o_valid/o_data after edge t+2. It can be consumed on edge t+3 at the earliest.
- Throughput: one sample per cycle while o_ready = 1.
- Capacity: 3 samples. With o_ready held low, i_ready deasserts once S1, S2 and S3 are all valid.
- Simultaneous events: if o_ready and i_valid are both 1 while full, the output is consumed and the input is accepted on the same edge, with no bubble.
- o_data, o_sat and o_uflow are stable while o_valid = 1 and o_ready = 0.
- Results leave in acceptance order.

## Configuration
- FXP2F_ROUND_EN defined: round-to-nearest-even.
  - guard = first bit of norm below mant; sticky = OR of all lower bits.
  - Increment when guard & (sticky | mant[0]).
- FXP2F_ROUND_EN undefined: truncate toward zero in magnitude; no carry path.

## Test plan
- WII=8, WIF=8: send 0x0180, 0xFF80, 0x0000, 0x8000 back-to-back with o_ready=1.
  - Required outputs: 0x3FC00000, 0xBF000000, 0x00000000, 0xC3000000 on consecutive cycles, first valid after edge t+2.
- WII=32, WIF=0: send 0x01000001 and 0x01000003.
  - With FXP2F_ROUND_EN: 0x4B800000 and 0x4B800002.
  - Without: 0x4B800000 and 0x4B800001.
- WII=32, WIF=0: send 0x00FFFFFF.
  - Both modes: 0x4B7FFFFF, because the value is exact.
- WII=131, WIF=0: send 2^129 → 0x7F7FFFFF with o_sat=1.
- WII=8, WIF=140: send 1 → 0x00000000 with o_uflow=1.
- Backpressure: stream 10 samples with o_ready low for 5 cycles mid-stream.
  - i_ready drops after 3 are held.
  - Held outputs stay stable.
  - All 10 results arrive in order with none lost or duplicated.
  - Assert rstn low with 2 in flight: o_valid=0 immediately and no stale output afterwards.
